// File: rtl/fifo_pkg.sv
// Shared definitions for the 32-bit synchronous FIFO and the blocks that
// drain it: default word/byte widths and width helper functions.
package fifo_pkg;

   localparam int FIFO_DATA_W = 32;
   localparam int BYTE_W      = 8;

   typedef logic [FIFO_DATA_W-1:0] fifo_word_t;

   // Number of bytes carried by one FIFO word.
   function automatic int nbytes(input int data_w, input int byte_w);
      return data_w / byte_w;
   endfunction

   // Width of a byte index; never narrower than one bit.
   function automatic int idx_width(input int nb);
      return (nb > 1) ? $clog2(nb) : 1;
   endfunction

endpackage

// File: rtl/fifo_byte_serializer_byte_select.sv
// Combinational byte extraction: returns byte number idx_i of word_i, where
// byte 0 is the most significant byte when MSB_FIRST is set and the least
// significant byte otherwise.
module byte_select
   import fifo_pkg::*;
#(
   parameter int DATA_W    = fifo_pkg::FIFO_DATA_W,
   parameter int BYTE_W    = fifo_pkg::BYTE_W,
   parameter bit MSB_FIRST = 1'b1,
   parameter int IDX_W     = fifo_pkg::idx_width(fifo_pkg::nbytes(DATA_W, BYTE_W))
) (
   input  logic [DATA_W-1:0] word_i,
   input  logic [IDX_W-1:0]  idx_i,
   output logic [BYTE_W-1:0] byte_o
);

   localparam int NB = nbytes(DATA_W, BYTE_W);

   logic [IDX_W-1:0] sel_s;

   // Map the transmit index onto a physical byte lane and shift it down.
   always_comb begin
      sel_s = idx_i;
      if (MSB_FIRST) begin
         sel_s = IDX_W'(NB - 1) - idx_i;
      end else begin
         sel_s = idx_i;
      end
      byte_o = BYTE_W'(word_i >> (32'(sel_s) * BYTE_W));
   end

endmodule

// File: rtl/fifo_byte_serializer.sv
// Drain stage for the 32-bit synchronous FIFO. Pops words with re/empty,
// captures the registered read data one cycle later, and emits each word as
// bytes on a valid/ready stream. A one-word prefetch buffer covers the FIFO
// read latency so a steady consumer sees one byte per cycle.
module fifo_byte_serializer
   import fifo_pkg::*;
#(
   parameter int DATA_W    = fifo_pkg::FIFO_DATA_W,
   parameter int BYTE_W    = fifo_pkg::BYTE_W,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   output logic              fifo_re,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic [BYTE_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [15:0]       word_count,
   output logic              busy
);

   localparam int NB    = nbytes(DATA_W, BYTE_W);
   localparam int IDX_W = idx_width(NB);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

   // Word being shifted out and its byte position.
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_valid_q, hold_valid_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   // Prefetched word waiting for hold to free up.
   logic [DATA_W-1:0] pf_q, pf_d;
   logic              pf_valid_q, pf_valid_d;
   // A FIFO read was issued last cycle; its data is on fifo_data now.
   logic              rd_pend_q, rd_pend_d;
   logic [15:0]       word_count_q, word_count_d;
   logic              out_last_q;
   logic              busy_q;

   logic [1:0]        occ_s;
   logic              fire_s;
   logic              last_fire_s;

   // Issue a read whenever fewer than two words are held, prefetched or in flight.
   always_comb begin
      occ_s = 2'(hold_valid_q) + 2'(pf_valid_q) + 2'(rd_pend_q);
      if (!rst && !fifo_empty && (occ_s < 2'd2)) begin
         fifo_re = 1'b1;
      end else begin
         fifo_re = 1'b0;
      end
   end

   // Next-state: consume the current byte first, then place any returning word.
   always_comb begin
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      idx_d        = idx_q;
      pf_d         = pf_q;
      pf_valid_d   = pf_valid_q;
      word_count_d = word_count_q;
      rd_pend_d    = fifo_re;
      fire_s       = hold_valid_q && out_ready;
      last_fire_s  = fire_s && (idx_q == LAST_IDX);

      if (last_fire_s) begin
         word_count_d = word_count_q + 16'd1;
         if (pf_valid_q) begin
            hold_d       = pf_q;
            hold_valid_d = 1'b1;
            idx_d        = {IDX_W{1'b0}};
            pf_valid_d   = 1'b0;
         end else begin
            hold_valid_d = 1'b0;
            idx_d        = {IDX_W{1'b0}};
         end
      end else if (fire_s) begin
         idx_d = idx_q + IDX_W'(1);
      end else begin
         idx_d = idx_q;
      end

      // Returning data goes to hold if it is empty after this cycle, else to pf.
      if (rd_pend_q) begin
         if (!hold_valid_d) begin
            hold_d       = fifo_data;
            hold_valid_d = 1'b1;
            idx_d        = {IDX_W{1'b0}};
         end else begin
            pf_d       = fifo_data;
            pf_valid_d = 1'b1;
         end
      end else begin
         pf_valid_d = pf_valid_d;
      end
   end

   // State and registered status outputs, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q       <= {DATA_W{1'b0}};
         hold_valid_q <= 1'b0;
         idx_q        <= {IDX_W{1'b0}};
         pf_q         <= {DATA_W{1'b0}};
         pf_valid_q   <= 1'b0;
         rd_pend_q    <= 1'b0;
         word_count_q <= 16'd0;
         out_last_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         idx_q        <= idx_d;
         pf_q         <= pf_d;
         pf_valid_q   <= pf_valid_d;
         rd_pend_q    <= rd_pend_d;
         word_count_q <= word_count_d;
         out_last_q   <= hold_valid_d && (idx_d == LAST_IDX);
         busy_q       <= hold_valid_d | pf_valid_d | rd_pend_d;
      end
   end

   byte_select #(
      .DATA_W    (DATA_W),
      .BYTE_W    (BYTE_W),
      .MSB_FIRST (MSB_FIRST),
      .IDX_W     (IDX_W)
   ) u_byte_select (
      .word_i (hold_q),
      .idx_i  (idx_q),
      .byte_o (out_data)
   );

   assign out_valid  = hold_valid_q;
   assign out_last   = out_last_q;
   assign word_count = word_count_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Self-checking bench for fifo_byte_serializer. Two instances (MSB-first and
// LSB-first) share one stimulus stream; a queue-based FIFO model and an
// expected-byte queue predict every output each cycle.
module tb_fifo_byte_serializer;

   typedef struct {
      logic [7:0] msb;
      logic [7:0] lsb;
      logic       last;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fifo_empty = 1'b1;
   logic [31:0] fifo_data = 32'd0;
   logic        out_ready = 1'b0;

   logic        m_re, m_valid, m_last, m_busy;
   logic [7:0]  m_data;
   logic [15:0] m_wc;
   logic        l_re, l_valid, l_last, l_busy;
   logic [7:0]  l_data;
   logic [15:0] l_wc;

   logic [31:0] fifo_q[$];
   ent_t        exp_q[$];
   logic [7:0]  got_msb[$];
   logic [7:0]  got_lsb[$];
   int          hs_cyc[$];

   int          n_vec = 0;
   int          n_err = 0;
   int          issued = 0;
   int          completed = 0;
   int          cyc_n = 0;
   int          first_re = -1;
   int          first_ov = -1;
   int          re_cnt = 0;
   logic        re_prev = 1'b0;
   logic        prev_rst = 1'b0;
   logic [15:0] wc_model = 16'd0;
   logic [7:0]  s_msb;
   logic        s_ov, s_re;

   always #5 clk = ~clk;

   fifo_byte_serializer #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .fifo_re(m_re), .fifo_empty(fifo_empty),
      .fifo_data(fifo_data), .out_data(m_data), .out_valid(m_valid),
      .out_ready(out_ready), .out_last(m_last), .word_count(m_wc), .busy(m_busy)
   );

   fifo_byte_serializer #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .fifo_re(l_re), .fifo_empty(fifo_empty),
      .fifo_data(fifo_data), .out_data(l_data), .out_valid(l_valid),
      .out_ready(out_ready), .out_last(l_last), .word_count(l_wc), .busy(l_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc_n);
      end
   endtask

   task automatic clr_log();
      got_msb.delete();
      got_lsb.delete();
      hs_cyc.delete();
      first_re = -1;
      first_ov = -1;
      re_cnt   = 0;
   endtask

   // One clock cycle: apply inputs, check outputs against the model, advance the model.
   task automatic cyc(input logic r, input logic rdy);
      ent_t        e;
      logic        re_s, fire_s, exp_ov;
      logic [7:0]  sl;
      logic [31:0] w;
      int          outst;
      @(negedge clk);
      rst        = r;
      out_ready  = rdy;
      fifo_empty = (fifo_q.size() == 0);
      #1;
      outst = issued - completed;
      if (r) begin
         chk("re_in_rst", m_re, 0);
         chk("re_in_rst_lsb", l_re, 0);
         if (prev_rst) begin
            chk("rst_valid", m_valid, 0);
            chk("rst_last", m_last, 0);
            chk("rst_data", m_data, 0);
            chk("rst_data_lsb", l_data, 0);
            chk("rst_wc", m_wc, 0);
            chk("rst_busy", m_busy, 0);
         end
      end else begin
         exp_ov = (outst - (re_prev ? 1 : 0)) > 0;
         chk("fifo_re", m_re, (!fifo_empty && outst < 2));
         chk("fifo_re_lsb", l_re, (!fifo_empty && outst < 2));
         chk("busy", m_busy, (outst != 0));
         chk("busy_lsb", l_busy, (outst != 0));
         chk("out_valid", m_valid, exp_ov);
         chk("out_valid_lsb", l_valid, exp_ov);
         if (exp_ov && exp_q.size() > 0) begin
            chk("out_data", m_data, exp_q[0].msb);
            chk("out_data_lsb", l_data, exp_q[0].lsb);
            chk("out_last", m_last, exp_q[0].last);
            chk("out_last_lsb", l_last, exp_q[0].last);
         end else begin
            chk("out_last_idle", m_last, 0);
            chk("out_last_idle_lsb", l_last, 0);
         end
         chk("word_count", m_wc, wc_model);
         chk("word_count_lsb", l_wc, wc_model);
      end
      s_msb  = m_data;
      s_ov   = m_valid;
      s_re   = m_re;
      sl     = l_data;
      re_s   = m_re && !r;
      fire_s = m_valid && rdy && !r;
      if (re_s) begin
         re_cnt++;
         if (first_re < 0) first_re = cyc_n;
      end
      if (m_valid && !r && first_ov < 0) first_ov = cyc_n;
      @(posedge clk);
      #1;
      if (r) begin
         exp_q.delete();
         issued    = 0;
         completed = 0;
         re_prev   = 1'b0;
         wc_model  = 16'd0;
      end else begin
         if (fire_s) begin
            got_msb.push_back(s_msb);
            got_lsb.push_back(sl);
            hs_cyc.push_back(cyc_n);
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL spurious_byte: got %h, expected no byte (cycle %0d)", s_msb, cyc_n);
            end else begin
               e = exp_q.pop_front();
               if (e.last) begin
                  completed++;
                  wc_model = wc_model + 16'd1;
               end
            end
         end
         if (re_s) begin
            if (fifo_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL read_when_empty: got re=1, expected re=0 (cycle %0d)", cyc_n);
            end else begin
               w = fifo_q.pop_front();
               fifo_data = w;
               issued++;
               for (int k = 0; k < 4; k++) begin
                  e.msb  = w[31-8*k -: 8];
                  e.lsb  = w[8*k +: 8];
                  e.last = (k == 3);
                  exp_q.push_back(e);
               end
            end
         end
         re_prev = re_s;
      end
      prev_rst = r;
      cyc_n++;
   endtask

   initial begin
      logic [7:0] t_m[4];
      logic [7:0] t_l[4];
      int         guard;
      t_m = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      t_l = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};

      // Reset held with a non-empty FIFO: no reads, all outputs zero.
      fifo_q.push_back(32'hA1B2C3D4);
      cyc(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
      clr_log();
      cyc(1'b0, 1'b1);
      chk("first_re_after_rst", s_re, 1);

      // Single word, both byte orders.
      for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1);
      chk("single_nbytes", got_msb.size(), 4);
      for (int k = 0; k < 4 && k < got_msb.size(); k++) begin
         chk("single_msb_byte", got_msb[k], t_m[k]);
         chk("single_lsb_byte", got_lsb[k], t_l[k]);
      end
      chk("single_wc", m_wc, 16'd1);
      chk("single_wc_lsb", l_wc, 16'd1);
      chk("single_busy_after", m_busy, 0);
      chk("single_latency", first_ov - first_re, 2);

      // Back-to-back words: gap-free byte stream 00..0B.
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      clr_log();
      fifo_q.push_back(32'h00010203);
      fifo_q.push_back(32'h04050607);
      fifo_q.push_back(32'h08090A0B);
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1);
      chk("b2b_nbytes", got_msb.size(), 12);
      for (int k = 0; k < 12 && k < got_msb.size(); k++) chk("b2b_byte", got_msb[k], k);
      if (hs_cyc.size() == 12) chk("b2b_gapfree", hs_cyc[11] - hs_cyc[0], 11);
      chk("b2b_wc", m_wc, 16'd3);

      // Backpressure: two reads only, output frozen, then all 16 bytes in order.
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      clr_log();
      fifo_q.push_back(32'h10111213);
      fifo_q.push_back(32'h14151617);
      fifo_q.push_back(32'h18191A1B);
      fifo_q.push_back(32'h1C1D1E1F);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 1'b0);
         if (i >= 2) chk("stall_frozen", s_msb, 8'h10);
      end
      chk("stall_reads", re_cnt, 2);
      for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1);
      chk("release_nbytes", got_msb.size(), 16);
      for (int k = 0; k < 16 && k < got_msb.size(); k++) begin
         chk("release_msb", got_msb[k], 8'h10 + k);
         chk("release_lsb", got_lsb[k], 8'h10 + 4 * (k / 4) + 3 - (k % 4));
      end

      // Reset mid-word with a prefetched word pending.
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      clr_log();
      fifo_q.push_back(32'h11223344);
      fifo_q.push_back(32'h55667788);
      fifo_q.push_back(32'h99AABBCC);
      guard = 0;
      while (got_msb.size() < 2 && guard < 20) begin
         cyc(1'b0, 1'b1);
         guard++;
      end
      chk("midrst_two_bytes", got_msb.size(), 2);
      chk("midrst_busy", m_busy, 1);
      cyc(1'b1, 1'b1);
      clr_log();
      cyc(1'b0, 1'b1);
      chk("midrst_valid_drop", s_ov, 0);
      chk("midrst_wc", m_wc, 16'd0);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1);
      chk("midrst_nbytes", got_msb.size(), 4);
      if (got_msb.size() > 0) chk("midrst_first_byte", got_msb[0], 8'h99);

      // Randomized traffic, backpressure and occasional resets.
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 2) == 0 && fifo_q.size() < 6) fifo_q.push_back($urandom);
         cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0));
      end
      guard = 0;
      while ((exp_q.size() > 0 || issued != completed || fifo_q.size() > 0) && guard < 300) begin
         cyc(1'b0, 1'b1);
         guard++;
      end
      chk("drain_empty", exp_q.size() + fifo_q.size(), 0);
      chk("drain_busy", m_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
